// File: rtl/lsu_ctrl.sv
// Load/store unit between EX/MEM and data_mem; misaligned halfword/word accesses are
// split into byte accesses, or trapped instead when LSU_MISALIGN_TRAP_EN is defined.

package rv_pkg;
  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HWORD = 2'b01,
    WORD  = 2'b10
  } mem_op_sz_e;
endpackage

module lsu_ctrl
  import rv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_mem_we,
  output logic        o_mem_re,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output mem_op_sz_e  o_mem_size,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    SPLIT  = 2'b10,
    RESP   = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic        is_unsigned_q, is_unsigned_d;
  logic        invalid_q, invalid_d;
  mem_op_sz_e  sz_q, sz_d;
  logic [31:0] raw_q, raw_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  mem_op_sz_e  mem_size_q, mem_size_d;
  logic        trapped;

`ifdef LSU_MISALIGN_TRAP_EN
  logic        trap_q, trap_d;
`else
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  k_q, k_d;
  logic [1:0]  k_last;
  logic [1:0]  k_next;
`endif

  logic        accept;
  logic        req_invalid;
  logic        req_misaligned;
  mem_op_sz_e  req_sz;
  logic [31:0] ext_data;

  assign o_ready = (state_q == IDLE) || (state_q == RESP);
  assign accept  = i_valid && o_ready;

  always_comb begin
    case (i_funct3[1:0])
      2'b00:   req_sz = BYTE;
      2'b01:   req_sz = HWORD;
      default: req_sz = WORD;
    endcase
    req_invalid = (i_funct3[1:0] == 2'b11) || (i_funct3[2] && i_funct3[1]) ||
                  (i_is_store && i_funct3[2]);
    req_misaligned = ((req_sz == HWORD) && i_addr[0]) ||
                     ((req_sz == WORD) && (i_addr[1:0] != 2'b00));
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trapped = trap_q;
`else
  assign trapped = 1'b0;
  assign k_last  = (sz_q == HWORD) ? 2'd1 : 2'd3;
  assign k_next  = k_q + 2'd1;
`endif

  always_comb begin
    state_d       = state_q;
    is_store_d    = is_store_q;
    is_unsigned_d = is_unsigned_q;
    invalid_d     = invalid_q;
    sz_d          = sz_q;
    raw_d         = raw_q;
    mem_we_d      = 1'b0;
    mem_re_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_size_d    = mem_size_q;
`ifdef LSU_MISALIGN_TRAP_EN
    trap_d        = trap_q;
`else
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    k_d           = k_q;
`endif

    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          is_store_d    = i_is_store;
          is_unsigned_d = i_funct3[2];
          invalid_d     = req_invalid;
          sz_d          = req_sz;
          raw_d         = '0;
`ifdef LSU_MISALIGN_TRAP_EN
          trap_d        = 1'b0;
`else
          addr_d        = i_addr;
          wdata_d       = i_wdata;
          k_d           = 2'd0;
`endif
          if (req_invalid) begin
            state_d = RESP;
          end else if (req_misaligned) begin
`ifdef LSU_MISALIGN_TRAP_EN
            // Pass through ACCESS with strobes low so the trap keeps aligned timing.
            trap_d  = 1'b1;
            state_d = ACCESS;
`else
            state_d     = SPLIT;
            mem_we_d    = i_is_store;
            mem_re_d    = !i_is_store;
            mem_addr_d  = i_addr;
            mem_wdata_d = {24'h0, i_wdata[7:0]};
            mem_size_d  = BYTE;
`endif
          end else begin
            state_d     = ACCESS;
            mem_we_d    = i_is_store;
            mem_re_d    = !i_is_store;
            mem_addr_d  = i_addr;
            mem_wdata_d = i_wdata;
            mem_size_d  = req_sz;
          end
        end
      end

      ACCESS: begin
        if (!is_store_q) raw_d = i_mem_rdata;
        state_d = RESP;
      end

`ifndef LSU_MISALIGN_TRAP_EN
      SPLIT: begin
        // Byte k of the request lands in byte lane k of the assembled word.
        if (!is_store_q) raw_d[{k_q, 3'b000} +: 8] = i_mem_rdata[7:0];
        if (k_q == k_last) begin
          state_d = RESP;
        end else begin
          k_d         = k_next;
          mem_we_d    = is_store_q;
          mem_re_d    = !is_store_q;
          mem_addr_d  = addr_q + {30'h0, k_next};
          mem_wdata_d = {24'h0, wdata_q[{k_next, 3'b000} +: 8]};
          mem_size_d  = BYTE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (sz_q)
      BYTE:    ext_data = is_unsigned_q ? {24'h0, raw_q[7:0]}
                                        : {{24{raw_q[7]}}, raw_q[7:0]};
      HWORD:   ext_data = is_unsigned_q ? {16'h0, raw_q[15:0]}
                                        : {{16{raw_q[15]}}, raw_q[15:0]};
      default: ext_data = raw_q;
    endcase
    o_rdata = '0;
    if ((state_q == RESP) && !is_store_q && !invalid_q && !trapped) o_rdata = ext_data;
  end

  assign o_done       = (state_q == RESP);
  assign o_misaligned = o_done && trapped;

  // Strobes are masked while reset is held so an interrupted split writes nothing more.
  assign o_mem_we    = mem_we_q && i_rst;
  assign o_mem_re    = mem_re_q && i_rst;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_size  = mem_size_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q       <= IDLE;
      is_store_q    <= 1'b0;
      is_unsigned_q <= 1'b0;
      invalid_q     <= 1'b0;
      sz_q          <= BYTE;
      raw_q         <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_size_q    <= BYTE;
`ifdef LSU_MISALIGN_TRAP_EN
      trap_q        <= 1'b0;
`else
      addr_q        <= '0;
      wdata_q       <= '0;
      k_q           <= 2'd0;
`endif
    end else begin
      state_q       <= state_d;
      is_store_q    <= is_store_d;
      is_unsigned_q <= is_unsigned_d;
      invalid_q     <= invalid_d;
      sz_q          <= sz_d;
      raw_q         <= raw_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_size_q    <= mem_size_d;
`ifdef LSU_MISALIGN_TRAP_EN
      trap_q        <= trap_d;
`else
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      k_q           <= k_d;
`endif
    end
  end

endmodule
